// File: rtl/exe_ctrl_queue.sv
// Per-lane completion buffer between writeback and the active list, with early issue-block credit.
// Optional same-cycle bypass when empty: define EXE_CTRL_QUEUE_BYPASS_EN.
package exe_ctrl_queue_pkg;
    typedef struct packed {
        logic        valid;
        logic [4:0]  al_id;
        logic        exception;
        logic        mispredict;
        logic [31:0] target;
    } ctrl_pkt_t;
endpackage

module exe_ctrl_queue
    import exe_ctrl_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SKID  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     recoverFlag_i,
    input  logic                     exceptionFlag_i,
    input  ctrl_pkt_t                ctrlPacket_i,
    input  logic                     alReady_i,
    output ctrl_pkt_t                ctrlPacket_o,
    output logic                     issueBlock_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ctrl_pkt_t         mem [DEPTH];
    logic [PW-1:0]     head, tail;
    logic [CW-1:0]     count, count_next;
    logic              flush, stored_vld, full;
    logic              bypass, pop, push_req, push, drop, block_next;

    assign flush      = recoverFlag_i | exceptionFlag_i;
    assign stored_vld = (count != '0);
    assign full       = (count == CW'(DEPTH));

`ifdef EXE_CTRL_QUEUE_BYPASS_EN
    // Reset term keeps the output all-zero while reset is held.
    assign bypass = reset & !stored_vld & alReady_i & !flush & ctrlPacket_i.valid;
`else
    assign bypass = 1'b0;
`endif

    assign pop      = stored_vld & alReady_i & !flush;
    assign push_req = ctrlPacket_i.valid & !flush & !bypass;
    // A pop on a full queue frees the slot the push lands in.
    assign push     = push_req & (!full | pop);
    assign drop     = push_req & full & !pop;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else
            count_next = count + CW'(push) - CW'(pop);
    end

    assign block_next = (DEPTH - int'(count_next)) <= SKID;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_o   <= 1'b0;
            issueBlock_o <= 1'b0;
        end else begin
            issueBlock_o <= block_next;
            count        <= count_next;
            if (drop)
                overflow_o <= 1'b1;
            if (flush) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= ctrlPacket_i;
    end

    always_comb begin
        ctrlPacket_o = '0;
        if (bypass)
            ctrlPacket_o = ctrlPacket_i;
        else if (stored_vld)
            ctrlPacket_o = mem[head];
    end

    assign count_o = count;
endmodule

// File: tb/tb_exe_ctrl_queue.sv
// Directed bench for exe_ctrl_queue (DEPTH=4, SKID=3); honours EXE_CTRL_QUEUE_BYPASS_EN.
module tb_exe_ctrl_queue;
    import exe_ctrl_queue_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      recover_flag, exception_flag, al_ready;
    ctrl_pkt_t pkt_in, pkt_out;
    logic      issue_block, overflow;
    logic [2:0] count;

    int vecs = 0;
    int errs = 0;

    exe_ctrl_queue #(.DEPTH(4), .SKID(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .recoverFlag_i   (recover_flag),
        .exceptionFlag_i (exception_flag),
        .ctrlPacket_i    (pkt_in),
        .alReady_i       (al_ready),
        .ctrlPacket_o    (pkt_out),
        .issueBlock_o    (issue_block),
        .count_o         (count),
        .overflow_o      (overflow)
    );

    always #5 clk = ~clk;

    function automatic ctrl_pkt_t mk(input int id);
        ctrl_pkt_t p;
        p.valid      = 1'b1;
        p.al_id      = id[4:0];
        p.exception  = id[0];
        p.mispredict = id[1];
        p.target     = 32'h1000 + 32'(id) * 4;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; recover_flag = 0; exception_flag = 0; al_ready = 0; pkt_in = '0;
        #2;
        vecs++; if (pkt_out !== '0) begin errs++; $display("FAIL reset_pkt: got %h want 0", pkt_out); end
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", count); end
        vecs++; if (issue_block !== 1'b0) begin errs++; $display("FAIL reset_issue: got %b want 0", issue_block); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        step(); step();
        reset = 1'b1;
    endtask

    task automatic test_single();
        al_ready = 1; pkt_in = mk(1);
        #1;
`ifdef EXE_CTRL_QUEUE_BYPASS_EN
        vecs++; if (pkt_out !== mk(1)) begin errs++; $display("FAIL single_bypass: got %h want %h", pkt_out, mk(1)); end
        step(); pkt_in = '0;
`else
        vecs++; if (pkt_out.valid !== 1'b0) begin errs++; $display("FAIL single_early: got %b want 0", pkt_out.valid); end
        step(); pkt_in = '0;
        vecs++; if (pkt_out !== mk(1)) begin errs++; $display("FAIL single_out: got %h want %h", pkt_out, mk(1)); end
        vecs++; if (count !== 3'd1) begin errs++; $display("FAIL single_cnt1: got %0d want 1", count); end
        vecs++; if (issue_block !== 1'b1) begin errs++; $display("FAIL single_issue1: got %b want 1", issue_block); end
        step();
`endif
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL single_cnt0: got %0d want 0", count); end
        vecs++; if (pkt_out.valid !== 1'b0) begin errs++; $display("FAIL single_vld0: got %b want 0", pkt_out.valid); end
        vecs++; if (issue_block !== 1'b0) begin errs++; $display("FAIL single_issue0: got %b want 0", issue_block); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL single_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_fill();
        al_ready = 0;
        for (int k = 0; k < 4; k++) begin
            pkt_in = mk(10 + k);
            step();
            if (k == 0) begin
                vecs++; if (issue_block !== 1'b1) begin errs++; $display("FAIL fill_issue_rise: got %b want 1", issue_block); end
            end
        end
        pkt_in = '0;
        vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fill_count: got %0d want 4", count); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL fill_ovf: got %b want 0", overflow); end
        vecs++; if (pkt_out !== mk(10)) begin errs++; $display("FAIL fill_head: got %h want %h", pkt_out, mk(10)); end
    endtask

    task automatic test_overflow();
        pkt_in = mk(14);
        step();
        pkt_in = '0;
        vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b want 1", overflow); end
        vecs++; if (count !== 3'd4) begin errs++; $display("FAIL ovf_count: got %0d want 4", count); end
        vecs++; if (pkt_out !== mk(10)) begin errs++; $display("FAIL ovf_head: got %h want %h", pkt_out, mk(10)); end
        step();
        vecs++; if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        do_reset();
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        ctrl_pkt_t exp_q[$];
        al_ready = 0;
        for (int k = 0; k < 4; k++) begin
            pkt_in = mk(10 + k);
            step();
        end
        al_ready = 1; pkt_in = mk(15);
        step();
        pkt_in = '0;
        vecs++; if (count !== 3'd4) begin errs++; $display("FAIL fpp_count: got %0d want 4", count); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL fpp_ovf: got %b want 0", overflow); end
        exp_q = '{mk(11), mk(12), mk(13), mk(15)};
        foreach (exp_q[i]) begin
            vecs++; if (pkt_out !== exp_q[i]) begin errs++; $display("FAIL fpp_order%0d: got %h want %h", i, pkt_out, exp_q[i]); end
            step();
        end
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL fpp_drained: got %0d want 0", count); end
        step();
        vecs++; if (count !== 3'd0 || pkt_out.valid !== 1'b0) begin errs++; $display("FAIL empty_pop: got cnt %0d vld %b want 0 0", count, pkt_out.valid); end
    endtask

    task automatic test_wrap();
        ctrl_pkt_t q[$];
        ctrl_pkt_t pk;
        logic push, ready, popm, fullm, byp;
        for (int i = 0; i < 20; i++) begin
            push  = (i % 2 == 0);
            ready = (i % 3 != 0);
            pk    = mk(20 + i / 2);
            pkt_in   = push ? pk : '0;
            al_ready = ready;
            #1;
            vecs++; if (count !== 3'(q.size())) begin errs++; $display("FAIL wrap_count%0d: got %0d want %0d", i, count, q.size()); end
            byp = 1'b0;
`ifdef EXE_CTRL_QUEUE_BYPASS_EN
            byp = (q.size() == 0) && ready && push;
`endif
            if (byp) begin
                vecs++; if (pkt_out !== pk) begin errs++; $display("FAIL wrap_byp%0d: got %h want %h", i, pkt_out, pk); end
            end else if (q.size() > 0) begin
                vecs++; if (pkt_out !== q[0]) begin errs++; $display("FAIL wrap_head%0d: got %h want %h", i, pkt_out, q[0]); end
            end
            fullm = (q.size() == 4);
            popm  = (q.size() > 0) && ready;
            if (popm) void'(q.pop_front());
            if (push && !byp && (!fullm || popm)) q.push_back(pk);
            step();
        end
        pkt_in = '0; al_ready = 1;
        for (int i = 0; i < 6 && q.size() > 0; i++) begin
            vecs++; if (pkt_out !== q[0]) begin errs++; $display("FAIL wrap_drain%0d: got %h want %h", i, pkt_out, q[0]); end
            void'(q.pop_front());
            step();
        end
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL wrap_empty: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        al_ready = 0;
        for (int k = 0; k < 3; k++) begin
            pkt_in = mk(30 + k);
            step();
        end
        vecs++; if (count !== 3'd3) begin errs++; $display("FAIL flush_pre: got %0d want 3", count); end
        recover_flag = 1; pkt_in = mk(33);
        #1;
        vecs++; if (pkt_out !== mk(30)) begin errs++; $display("FAIL flush_preout: got %h want %h", pkt_out, mk(30)); end
        step();
        recover_flag = 0; pkt_in = '0;
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL flush_count: got %0d want 0", count); end
        vecs++; if (pkt_out.valid !== 1'b0) begin errs++; $display("FAIL flush_vld: got %b want 0", pkt_out.valid); end
        vecs++; if (issue_block !== 1'b0) begin errs++; $display("FAIL flush_issue: got %b want 0", issue_block); end
        pkt_in = mk(34);
        step();
        exception_flag = 1; al_ready = 1; pkt_in = '0;
        step();
        exception_flag = 0; al_ready = 0;
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL exc_flush: got %0d want 0", count); end
        pkt_in = mk(35);
        step();
        pkt_in = '0;
        vecs++; if (pkt_out !== mk(35)) begin errs++; $display("FAIL post_flush: got %h want %h", pkt_out, mk(35)); end
    endtask

    task automatic test_async_reset();
        pkt_in = mk(36);
        step();
        pkt_in = '0;
        #2;
        reset = 1'b0;
        #1;
        vecs++; if (count !== 3'd0) begin errs++; $display("FAIL async_count: got %0d want 0", count); end
        vecs++; if (pkt_out !== '0) begin errs++; $display("FAIL async_pkt: got %h want 0", pkt_out); end
        vecs++; if (issue_block !== 1'b0) begin errs++; $display("FAIL async_issue: got %b want 0", issue_block); end
        reset = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        step();
        test_single();
        test_fill();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/exe_ctrl_queue.md
# exe_ctrl_queue

Completion buffer between one execution lane's writeback stage and the active list. It captures every valid control packet the lane produces. The lane has no stall input, so the queue can never refuse a packet. It holds packets until the active list accepts them and raises an early-warning credit signal so the issue scheduler stops selecting the lane before the queue can overflow. One instance sits per execution lane, directly downstream of the lane's ctrlPacket_o.

## Interface
- DEPTH, 4: number of entries; power of two, at least 2.
- SKID, 3: in-flight packets that may still arrive after issue is blocked; equals the issue-to-writeback latency; SKID < DEPTH.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset; asserted when low.
- recoverFlag_i  in  1  branch-recovery flush.
- exceptionFlag_i  in  1  exception flush.
- ctrlPacket_i  in  ctrlPkt  packet from the lane's writeback; push when .valid = 1.
- alReady_i  in  1  active list accepts the head packet this cycle.
- ctrlPacket_o  out  ctrlPkt  head packet; .valid = 1 when the queue is non-empty.
- issueBlock_o  out  1  tells the issue scheduler not to select this lane.
- count_o  out  log2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky error: a push was dropped because the queue was full.

## Operation
- Storage is a circular buffer with wrapping head and tail pointers of log2(DEPTH) bits, plus a count register.
- **Push:** occurs when ctrlPacket_i.valid = 1 and no flush is active. The packet is written at the tail, and the tail advances modulo DEPTH.
- **Pop:** occurs when ctrlPacket_o.valid = 1 and alReady_i = 1. The head advances modulo DEPTH.
- **Simultaneous push and pop:** count is unchanged. When the queue is full, the pop frees the slot the push uses in the same cycle, so the push is accepted and overflow_o does not set.
- **Push while full without a pop:** the packet is dropped, overflow_o is set to 1, and it holds until reset.
- **Flush** (recoverFlag_i | exceptionFlag_i):
  - Head, tail and count are cleared synchronously at the next edge.
  - A push or pop in the same cycle is ignored.
  - ctrlPacket_o.valid is still driven combinationally from the pre-flush state during the flush cycle. The active list ignores it under flush.
- **issueBlock_o** = (DEPTH − count_next) ≤ SKID, where count_next is the registered next-cycle count. It is registered, so it is high in the cycle after the condition arises.
- The output payload comes from a register or array read at the head. No field of the packet is modified.

## Timing
- All outputs go to zero during reset: ctrlPacket_o.valid = 0 with all other fields 0, issueBlock_o = 0, count_o = 0, overflow_o = 0.
- Latency from push at edge N to ctrlPacket_o.valid = 1 is 1 cycle (the cycle after edge N), when the queue was empty.
- There are no combinational paths from ctrlPacket_i to any output (except in the bypass configuration below).
- alReady_i → pop takes effect at the next edge. ctrlPacket_o is combinational from the head pointer only.
- Reset asserted mid-operation discards all contents immediately, asynchronously.
- Boundaries that must be handled: empty with pop request (no-op), full with push (drop and set overflow_o), pointer wrap from DEPTH−1 to 0, flush together with push.

## Configuration
- **EXE_CTRL_QUEUE_BYPASS_EN defined:**
  - When the queue is empty, alReady_i = 1, no flush is active and ctrlPacket_i.valid = 1, the input is driven straight onto ctrlPacket_o in the same cycle and is not stored (0-cycle latency).
  - If alReady_i = 0 in that case, the packet is stored as normal.
- **EXE_CTRL_QUEUE_BYPASS_EN not defined:** every packet is stored and latency is always ≥ 1 cycle.

## Test plan
- **Reset and single packet:** release reset, push one packet with alReady_i = 1. The output must be valid exactly one cycle later (same cycle with bypass), count_o returns to 0, and overflow_o stays 0.
- **Fill and credit:** DEPTH = 4, SKID = 3, alReady_i = 0, push 4 packets on consecutive cycles. issueBlock_o must rise the cycle after the 1st push, count_o must reach 4, and overflow_o must stay 0.
- **Overflow:** with the queue full and alReady_i = 0, push a 5th packet. overflow_o must go to 1 and stay 1, count_o must stay 4, and the head packet must be unchanged.
- **Full with simultaneous push and pop:** alReady_i = 1 plus a push. count_o must stay 4, no overflow, and the output order must match the push order.
- **Wrap-around:** push and drain 10 packets with alternating alReady_i. Output order must equal input order across the pointer wrap.
- **Flush:** with 3 entries held, assert recoverFlag_i together with a push. The next cycle must show count_o = 0, ctrlPacket_o.valid = 0 and issueBlock_o = 0.
